// File: rtl/frame_filler.sv
// frame_filler
//   Fill engine on the graphics-processor fill interface. It accepts one fill
//   command and paints every pixel of a WIDTH x HEIGHT frame with a 24-bit
//   colour. The writes go out as bursts into the DDR2 request controller's
//   address FIFO (af) and write-data FIFO (wdf). Each burst is 8 pixels of
//   32 bits, carried as one af entry plus two 128-bit wdf words.
//
//   Optional feature: define FRAME_FILLER_DONE_EN to add the `done` output.
//   `done` is a one-cycle pulse in the first idle cycle after the final write.
//
// Parameters
//   WIDTH   pixels per row (multiple of 8, <= 1024)
//   HEIGHT  rows per frame (<= 1024)
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   valid         fill command present
//   color         fill colour {R,G,B}
//   frame         frame base byte address (only frame[27:22] is used)
//   ready         idle, a command can be accepted
//   af_full       address FIFO full
//   af_wr_en      push af_addr_din
//   af_addr_din   burst address
//   wdf_full      write-data FIFO full
//   wdf_wr_en     push wdf_din / wdf_mask_din
//   wdf_din       write data (four copies of {8'h00, colour})
//   wdf_mask_din  byte mask (1 = byte not written), always 0
//   done          (FRAME_FILLER_DONE_EN only) completion pulse
module frame_filler #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [23:0]  color,
  input  logic [31:0]  frame,
  output logic         ready,
  input  logic         af_full,
  output logic         af_wr_en,
  output logic [30:0]  af_addr_din,
  input  logic         wdf_full,
  output logic         wdf_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din
`ifdef FRAME_FILLER_DONE_EN
  ,
  output logic         done
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR1,
    ST_WR2
  } state_t;

  // x is held as a burst index (x/8): only x[9:3] ever reaches the address.
  localparam logic [6:0] XB_LAST = 7'((WIDTH / 8) - 1);
  localparam logic [9:0] Y_LAST  = 10'(HEIGHT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_xb;
  logic [9:0]  r_y;
  logic [23:0] r_color;
  logic [5:0]  r_frame;

  logic        w_accept;
  logic        w_wr2_push;
  logic        w_last;
  logic        w_unused_frame;

  assign w_unused_frame = ^{frame[31:28], frame[21:0]};

  assign w_accept   = (r_state == ST_IDLE) && valid;
  assign w_wr2_push = (r_state == ST_WR2) && !wdf_full;
  assign w_last     = (r_xb == XB_LAST) && (r_y == Y_LAST);

  assign ready        = (r_state == ST_IDLE);
  assign af_addr_din  = {6'b0, r_frame, r_y, r_xb, 2'b00};
  assign wdf_din      = {4{8'h00, r_color}};
  assign wdf_mask_din = '0;

  always_comb begin
    w_state_nxt = r_state;
    af_wr_en    = 1'b0;
    wdf_wr_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid) w_state_nxt = ST_WR1;
      end
      ST_WR1: begin
        // The address is pushed only when its first data word can go too.
        if (!af_full && !wdf_full) begin
          af_wr_en    = 1'b1;
          wdf_wr_en   = 1'b1;
          w_state_nxt = ST_WR2;
        end
      end
      ST_WR2: begin
        if (!wdf_full) begin
          wdf_wr_en   = 1'b1;
          w_state_nxt = w_last ? ST_IDLE : ST_WR1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // The partial burst is abandoned at reset, so nothing is pushed on the reset edge.
    if (rst) begin
      af_wr_en  = 1'b0;
      wdf_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_xb    <= '0;
      r_y     <= '0;
      r_color <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_color <= color;
        r_frame <= frame[27:22];
        r_xb    <= '0;
        r_y     <= '0;
      end
      if (w_wr2_push) begin
        if (r_xb == XB_LAST) begin
          r_xb <= '0;
          // After the last row the counters return to 0 instead of passing HEIGHT-1.
          r_y  <= w_last ? '0 : r_y + 10'd1;
        end else begin
          r_xb <= r_xb + 7'd1;
        end
      end
    end
  end

`ifdef FRAME_FILLER_DONE_EN
  logic r_done;

  always_ff @(posedge clk) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= w_wr2_push && w_last;
  end

  assign done = r_done;
`endif

endmodule

// File: tb/tb_frame_filler.sv
// tb_frame_filler
//   Directed bench for frame_filler. It uses two instances:
//     u_big   default 800x600 frame; checks addressing, data, and mid-fill reset.
//     u_small 16x2 frame; checks backpressure, ignored commands, latency and counts.
//   Set FRAME_FILLER_DONE_EN to also connect and check the done pulse.
module tb_frame_filler;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // default-size instance
  logic         b_rst, b_valid, b_ready, b_af_full, b_af_wr_en, b_wdf_full, b_wdf_wr_en;
  logic [23:0]  b_color;
  logic [31:0]  b_frame;
  logic [30:0]  b_af_addr_din;
  logic [127:0] b_wdf_din;
  logic [15:0]  b_wdf_mask_din;

  // 16x2 instance
  logic         s_rst, s_valid, s_ready, s_af_full, s_af_wr_en, s_wdf_full, s_wdf_wr_en;
  logic [23:0]  s_color;
  logic [31:0]  s_frame;
  logic [30:0]  s_af_addr_din;
  logic [127:0] s_wdf_din;
  logic [15:0]  s_wdf_mask_din;

`ifdef FRAME_FILLER_DONE_EN
  logic b_done, s_done;
`endif

  frame_filler u_big (
    .clk(clk), .rst(b_rst), .valid(b_valid), .color(b_color), .frame(b_frame),
    .ready(b_ready), .af_full(b_af_full), .af_wr_en(b_af_wr_en), .af_addr_din(b_af_addr_din),
    .wdf_full(b_wdf_full), .wdf_wr_en(b_wdf_wr_en), .wdf_din(b_wdf_din),
    .wdf_mask_din(b_wdf_mask_din)
`ifdef FRAME_FILLER_DONE_EN
    , .done(b_done)
`endif
  );

  frame_filler #(.WIDTH(16), .HEIGHT(2)) u_small (
    .clk(clk), .rst(s_rst), .valid(s_valid), .color(s_color), .frame(s_frame),
    .ready(s_ready), .af_full(s_af_full), .af_wr_en(s_af_wr_en), .af_addr_din(s_af_addr_din),
    .wdf_full(s_wdf_full), .wdf_wr_en(s_wdf_wr_en), .wdf_din(s_wdf_din),
    .wdf_mask_din(s_wdf_mask_din)
`ifdef FRAME_FILLER_DONE_EN
    , .done(s_done)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Push monitors. They sample on the falling edge; inputs change only
  // 1 time unit after the rising edge.
  logic [23:0] b_exp_color, s_exp_color;
  int b_af_cnt = 0, b_wdf_cnt = 0, b_bad = 0, b_orphan = 0;
  int s_af_cnt = 0, s_wdf_cnt = 0, s_bad = 0, s_orphan = 0;
  logic [30:0] s_addr_log [0:63];

  always @(negedge clk) begin
    if (b_af_wr_en === 1'b1) begin
      b_af_cnt++;
      if (b_wdf_wr_en !== 1'b1) b_orphan++;
    end
    if (b_wdf_wr_en === 1'b1) begin
      b_wdf_cnt++;
      if (b_wdf_din !== {4{8'h00, b_exp_color}} || b_wdf_mask_din !== 16'h0000) b_bad++;
    end
  end

  always @(negedge clk) begin
    if (s_af_wr_en === 1'b1) begin
      if (s_af_cnt < 64) s_addr_log[s_af_cnt] = s_af_addr_din;
      s_af_cnt++;
      if (s_wdf_wr_en !== 1'b1) s_orphan++;
    end
    if (s_wdf_wr_en === 1'b1) begin
      s_wdf_cnt++;
      if (s_wdf_din !== {4{8'h00, s_exp_color}} || s_wdf_mask_din !== 16'h0000) s_bad++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int n;
  int base_af, base_wdf;

  initial begin
    b_rst = 1'b1; b_valid = 1'b0; b_color = '0; b_frame = '0; b_af_full = 1'b0; b_wdf_full = 1'b0;
    s_rst = 1'b1; s_valid = 1'b0; s_color = '0; s_frame = '0; s_af_full = 1'b0; s_wdf_full = 1'b0;
    b_exp_color = '0; s_exp_color = '0;

    // 1. reset held for 3 cycles
    repeat (3) begin
      tick();
      chk("rst_ready", b_ready, 1);
      chk("rst_af_wr_en", b_af_wr_en, 0);
      chk("rst_wdf_wr_en", b_wdf_wr_en, 0);
    end
    b_rst = 1'b0;
    s_rst = 1'b0;
    tick();
    chk("post_rst_ready", b_ready, 1);
    chk("post_rst_af_wr_en", b_af_wr_en, 0);
    chk("post_rst_wdf_wr_en", b_wdf_wr_en, 0);
    chk("post_rst_s_ready", s_ready, 1);

    // 2. default frame, green, frame[27:22]=1
    b_color = 24'h00FF00; b_exp_color = 24'h00FF00; b_frame = 32'h10400000; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("first_ready", b_ready, 0);
    chk("first_af_wr_en", b_af_wr_en, 1);
    chk("first_wdf_wr_en", b_wdf_wr_en, 1);
    chk("first_addr", b_af_addr_din, 31'h0080000);
    chk("first_wdf_din", b_wdf_din, {4{32'h0000FF00}});
    chk("first_mask", b_wdf_mask_din, 16'h0000);
    n = 0;
    while (b_af_cnt < 10 && n < 100) begin tick(); n++; end
    chk("ten_bursts_in_time", n < 100, 1);
    chk("burst10_wdf_cnt", b_wdf_cnt, 19);
    chk("burst10_in_wr2", b_wdf_wr_en, 1);
    chk("burst10_addr", b_af_addr_din, 31'h0080024);

    // 6. reset mid-fill
    b_rst = 1'b1;
    tick();
    chk("midrst_ready", b_ready, 1);
    chk("midrst_af_wr_en", b_af_wr_en, 0);
    chk("midrst_wdf_wr_en", b_wdf_wr_en, 0);
    b_rst = 1'b0;
    repeat (3) tick();
    chk("midrst_af_cnt", b_af_cnt, 10);
    chk("midrst_wdf_cnt", b_wdf_cnt, 19);
    chk("midrst_still_ready", b_ready, 1);
    b_color = 24'h0000FF; b_exp_color = 24'h0000FF; b_frame = 32'h0; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("restart_af_wr_en", b_af_wr_en, 1);
    chk("restart_addr", b_af_addr_din, 31'h0);
    chk("restart_wdf_din", b_wdf_din, {4{32'h000000FF}});
    tick();
    tick();
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    chk("big_bad_data", b_bad, 0);
    chk("big_orphan_af", b_orphan, 0);

    // 3. 16x2 frame, af_full held for 5 cycles in WR1
    s_color = 24'h000001; s_exp_color = 24'h000001; s_frame = 32'h0;
    s_af_full = 1'b1; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (5) begin
      chk("afhold_af_wr_en", s_af_wr_en, 0);
      chk("afhold_wdf_wr_en", s_wdf_wr_en, 0);
      chk("afhold_busy", s_ready, 0);
      tick();
    end
    chk("afhold_af_cnt", s_af_cnt, 0);
    chk("afhold_wdf_cnt", s_wdf_cnt, 0);
    s_af_full = 1'b0;
    #1;
    chk("afrel_af_wr_en", s_af_wr_en, 1);
    n = 0;
    while (!s_ready && n < 50) begin tick(); n++; end
    chk("t3_done_in_time", n < 50, 1);
    chk("t3_af_cnt", s_af_cnt, 4);
    chk("t3_wdf_cnt", s_wdf_cnt, 8);
    chk("t3_addr0", s_addr_log[0], 31'h000);
    chk("t3_addr1", s_addr_log[1], 31'h004);
    chk("t3_addr2", s_addr_log[2], 31'h200);
    chk("t3_addr3", s_addr_log[3], 31'h204);

    // 4/5. wdf_full for 3 cycles in WR2, plus a command that must be ignored
    base_af = s_af_cnt; base_wdf = s_wdf_cnt;
    s_color = 24'hABCDEF; s_exp_color = 24'hABCDEF; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    s_wdf_full = 1'b1;
    #1;
    chk("wdfhold_wdf_wr_en", s_wdf_wr_en, 0);
    chk("wdfhold_af_wr_en", s_af_wr_en, 0);
    s_valid = 1'b1; s_color = 24'h123456;
    tick();
    s_valid = 1'b0;
    repeat (2) begin
      chk("wdfhold_wdf_wr_en_n", s_wdf_wr_en, 0);
      tick();
    end
    chk("wdfhold_af_delta", s_af_cnt - base_af, 1);
    chk("wdfhold_wdf_delta", s_wdf_cnt - base_wdf, 1);
    s_wdf_full = 1'b0;
    #1;
    chk("wdfrel_wdf_wr_en", s_wdf_wr_en, 1);
    n = 0;
    while (!s_ready && n < 50) begin tick(); n++; end
    chk("t4_done_in_time", n < 50, 1);
`ifdef FRAME_FILLER_DONE_EN
    chk("t4_done_pulse", s_done, 1);
    tick();
    chk("t4_done_low", s_done, 0);
`endif
    chk("t4_af_delta", s_af_cnt - base_af, 4);
    chk("t4_wdf_delta", s_wdf_cnt - base_wdf, 8);
    repeat (4) tick();
    chk("t5_no_extra_fill", s_wdf_cnt - base_wdf, 8);
    chk("t5_idle", s_ready, 1);
    chk("t5_keep_color", s_wdf_din, {4{32'h00ABCDEF}});

    // latency with no backpressure: 4 bursts, 8 busy cycles
    base_af = s_af_cnt; base_wdf = s_wdf_cnt;
    s_color = 24'h00FF00; s_exp_color = 24'h00FF00; s_frame = 32'h10400000; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("lat_first_af", s_af_wr_en, 1);
    chk("lat_first_addr", s_af_addr_din, 31'h0080000);
    n = 0;
    while (!s_ready && n < 50) begin
`ifdef FRAME_FILLER_DONE_EN
      chk("lat_no_early_done", s_done, 0);
`endif
      tick();
      n++;
    end
    chk("lat_busy_cycles", n, 8);
    chk("lat_af_delta", s_af_cnt - base_af, 4);
    chk("lat_wdf_delta", s_wdf_cnt - base_wdf, 8);
    chk("lat_last_addr", s_addr_log[base_af + 3], 31'h0080204);
    chk("small_bad_data", s_bad, 0);
    chk("small_orphan_af", s_orphan, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
